// File: rtl/ps2_scan_tracker.sv
// ps2_scan_tracker
// ----------------
// Turns the stream of validated PS/2 scan-code bytes into complete key
// events. The E0 (extended), F0 (break) and E1 (pause) prefix sequences are
// folded into a single event {code, ext, break}, which is queued in a small
// show-ahead FIFO. An optional repeat filter drops typematic repeat makes.
//
// All sequential logic runs on the falling edge of clk_rx. reset is
// asynchronous and active low.
//
// Handshake: ev_valid is high whenever the FIFO holds at least one event, and
// ev_code/ev_ext/ev_break then describe the head event. The head is consumed
// on a falling edge where ev_valid && ev_ready. While ev_valid=1 and
// ev_ready=0, the ev_* outputs hold. When ev_valid=0, ev_ready has no effect.
//
// Ports:
//   clk_rx     in   system clock (negedge active)
//   reset      in   asynchronous active-low reset
//   Din        in   received scan-code byte
//   din_valid  in   one-cycle strobe, Din is a new byte
//   ev_ready   in   consumer accepts the head event
//   ovf_clr    in   clears overflow (a new overflow the same cycle wins)
//   ev_valid   out  FIFO non-empty
//   ev_code    out  head event key code (PAUSE_CODE for pause)
//   ev_ext     out  head event carried the E0 prefix
//   ev_break   out  head event is a release
//   bandera    out  break prefix pending (state BRK or EXT_BRK)
//   proto_err  out  one-cycle pulse after an illegal prefix byte
//   overflow   out  sticky, an event was dropped on a full FIFO
//   fill       out  FIFO occupancy
module ps2_scan_tracker #(
  parameter logic [7:0] BREAK_CODE    = 8'hF0,
  parameter logic [7:0] EXT_CODE      = 8'hE0,
  parameter logic [7:0] PAUSE_CODE    = 8'hE1,
  parameter int         PAUSE_LEN     = 8,
  parameter int         DEPTH         = 4,
  parameter bit         FILTER_REPEAT = 1'b0
) (
  input  logic                       clk_rx,
  input  logic                       reset,
  input  logic [7:0]                 Din,
  input  logic                       din_valid,
  input  logic                       ev_ready,
  input  logic                       ovf_clr,
  output logic                       ev_valid,
  output logic [7:0]                 ev_code,
  output logic                       ev_ext,
  output logic                       ev_break,
  output logic                       bandera,
  output logic                       proto_err,
  output logic                       overflow,
  output logic [$clog2(DEPTH):0]     fill
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int FW = $clog2(DEPTH) + 1;
  localparam int CW = $clog2(PAUSE_LEN + 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_EXT     = 3'd1,
    S_BRK     = 3'd2,
    S_EXT_BRK = 3'd3,
    S_PAUSE   = 3'd4
  } state_t;

  state_t        state, state_n;
  logic [CW-1:0] pause_cnt, pause_cnt_n;

  // Decoder outputs for the current byte.
  logic       dec_push;
  logic [7:0] dec_code;
  logic       dec_ext;
  logic       dec_brk;
  logic       err_n;

  logic is_prefix;
  logic is_ignored;

  // Byte classification.
  always_comb begin
    is_prefix  = (Din == BREAK_CODE) || (Din == EXT_CODE) || (Din == PAUSE_CODE);
    // Keyboard status/acknowledge bytes carry no key information in IDLE.
    is_ignored = Din inside {8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF};
  end

  // Next-state and decoded event.
  always_comb begin
    state_n     = state;
    pause_cnt_n = pause_cnt;
    dec_push    = 1'b0;
    dec_code    = Din;
    dec_ext     = 1'b0;
    dec_brk     = 1'b0;
    err_n       = 1'b0;

    if (din_valid) begin
      unique case (state)
        S_IDLE: begin
          if (Din == EXT_CODE) begin
            state_n = S_EXT;
          end else if (Din == BREAK_CODE) begin
            state_n = S_BRK;
          end else if (Din == PAUSE_CODE) begin
            state_n     = S_PAUSE;
            pause_cnt_n = CW'(1);
          end else if (!is_ignored) begin
            dec_push = 1'b1;
          end
        end

        S_EXT: begin
          if (Din == BREAK_CODE) begin
            state_n = S_EXT_BRK;
          end else if ((Din == EXT_CODE) || (Din == PAUSE_CODE)) begin
            err_n   = 1'b1;
            state_n = S_IDLE;
          end else begin
            dec_push = 1'b1;
            dec_ext  = 1'b1;
            state_n  = S_IDLE;
          end
        end

        S_BRK: begin
          state_n = S_IDLE;
          if (is_prefix) begin
            err_n = 1'b1;
          end else begin
            dec_push = 1'b1;
            dec_brk  = 1'b1;
          end
        end

        S_EXT_BRK: begin
          state_n = S_IDLE;
          if (is_prefix) begin
            err_n = 1'b1;
          end else begin
            dec_push = 1'b1;
            dec_ext  = 1'b1;
            dec_brk  = 1'b1;
          end
        end

        S_PAUSE: begin
          // Pause bytes are counted, not inspected.
          if (pause_cnt + CW'(1) == CW'(PAUSE_LEN)) begin
            dec_push    = 1'b1;
            dec_code    = PAUSE_CODE;
            pause_cnt_n = '0;
            state_n     = S_IDLE;
          end else begin
            pause_cnt_n = pause_cnt + CW'(1);
          end
        end

        default: begin
          state_n     = S_IDLE;
          pause_cnt_n = '0;
        end
      endcase
    end
  end

  // bandera is its own flop so consumers never see a decode glitch.
  always_ff @(negedge clk_rx or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      pause_cnt <= '0;
      bandera   <= 1'b0;
      proto_err <= 1'b0;
    end else begin
      state     <= state_n;
      pause_cnt <= pause_cnt_n;
      bandera   <= (state_n == S_BRK) || (state_n == S_EXT_BRK);
      proto_err <= err_n;
    end
  end

  // Repeat filter. The register holds the last make that left the decoder
  // ({code, ext}); a release of that key re-arms it.
  logic       rep_valid;
  logic [7:0] rep_code;
  logic       rep_ext;
  logic       rep_hit;
  logic       ev_push;

  always_comb begin
    rep_hit = FILTER_REPEAT && rep_valid && (dec_code == rep_code) && (dec_ext == rep_ext);
    ev_push = dec_push && !(rep_hit && !dec_brk);
  end

  always_ff @(negedge clk_rx or negedge reset) begin
    if (!reset) begin
      rep_valid <= 1'b0;
      rep_code  <= '0;
      rep_ext   <= 1'b0;
    end else if (FILTER_REPEAT && dec_push) begin
      if (dec_brk) begin
        if (rep_hit) rep_valid <= 1'b0;
      end else begin
        rep_valid <= 1'b1;
        rep_code  <= dec_code;
        rep_ext   <= dec_ext;
      end
    end
  end

  // Event FIFO, entries packed as {code, ext, brk}.
  logic [9:0]    mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [FW-1:0] cnt;
  logic          full;
  logic          pop;
  logic          wr;
  logic          drop;
  logic [9:0]    head;

  always_comb begin
    full = (cnt == FW'(DEPTH));
    pop  = (cnt != '0) && ev_ready;
    // A full FIFO still accepts when the head leaves on the same edge.
    wr   = ev_push && (!full || pop);
    drop = ev_push && full && !pop;
    head = mem[rptr];
  end

  always_ff @(negedge clk_rx or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wptr     <= '0;
      rptr     <= '0;
      cnt      <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr) begin
        mem[wptr] <= {dec_code, dec_ext, dec_brk};
        wptr      <= wptr + AW'(1);
      end
      if (pop) rptr <= rptr + AW'(1);
      unique case ({wr, pop})
        2'b10:   cnt <= cnt + FW'(1);
        2'b01:   cnt <= cnt - FW'(1);
        default: cnt <= cnt;
      endcase
      if (drop)         overflow <= 1'b1;
      else if (ovf_clr) overflow <= 1'b0;
    end
  end

  assign ev_valid = (cnt != '0);
  assign ev_code  = ev_valid ? head[9:2] : 8'h00;
  assign ev_ext   = ev_valid & head[1];
  assign ev_break = ev_valid & head[0];
  assign fill     = cnt;

endmodule

// File: tb/tb_ps2_scan_tracker.sv
// Bench for ps2_scan_tracker: one instance without and one with the repeat
// filter share the same inputs. A byte-level reference decoder (prefix list
// plus pause countdown) feeds per-instance expected queues; a monitor compares
// the DUT heads, fill, overflow, bandera and proto_err every cycle.
module tb_ps2_scan_tracker;

  localparam int DEPTH     = 4;
  localparam int PAUSE_LEN = 8;
  localparam int FW        = $clog2(DEPTH) + 1;

  // Clock / reset
  logic clk_rx = 1'b0;
  logic reset  = 1'b1;
  always #5 clk_rx = ~clk_rx;

  logic [7:0] din       = 8'h00;
  logic       din_valid = 1'b0;
  logic       ev_ready  = 1'b0;
  logic       ovf_clr   = 1'b0;

  logic          ev_valid0, ev_ext0, ev_break0, bandera0, proto_err0, overflow0;
  logic [7:0]    ev_code0;
  logic [FW-1:0] fill0;
  logic          ev_valid1, ev_ext1, ev_break1, bandera1, proto_err1, overflow1;
  logic [7:0]    ev_code1;
  logic [FW-1:0] fill1;

  ps2_scan_tracker #(.PAUSE_LEN(PAUSE_LEN), .DEPTH(DEPTH), .FILTER_REPEAT(1'b0)) u0 (
    .clk_rx(clk_rx), .reset(reset), .Din(din), .din_valid(din_valid),
    .ev_ready(ev_ready), .ovf_clr(ovf_clr), .ev_valid(ev_valid0),
    .ev_code(ev_code0), .ev_ext(ev_ext0), .ev_break(ev_break0),
    .bandera(bandera0), .proto_err(proto_err0), .overflow(overflow0), .fill(fill0)
  );

  ps2_scan_tracker #(.PAUSE_LEN(PAUSE_LEN), .DEPTH(DEPTH), .FILTER_REPEAT(1'b1)) u1 (
    .clk_rx(clk_rx), .reset(reset), .Din(din), .din_valid(din_valid),
    .ev_ready(ev_ready), .ovf_clr(ovf_clr), .ev_valid(ev_valid1),
    .ev_code(ev_code1), .ev_ext(ev_ext1), .ev_break(ev_break1),
    .bandera(bandera1), .proto_err(proto_err1), .overflow(overflow1), .fill(fill1)
  );

  // Scoreboard state
  int total = 0;
  int bad   = 0;
  logic [9:0] exp_q0[$];   // {code, ext, brk}
  logic [9:0] exp_q1[$];
  logic [7:0] pfx[$];      // prefix bytes seen in the current sequence
  int         pause_left = 0;
  logic       m_perr = 1'b0;
  logic       m_band = 1'b0;
  logic       m_ovf[2]     = '{1'b0, 1'b0};
  logic       rep_valid[2] = '{1'b0, 1'b0};
  logic [8:0] rep_key[2]   = '{9'h0, 9'h0};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit is_ign(input logic [7:0] b);
    return b inside {8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF};
  endfunction

  function automatic int q_size(input int k);
    return (k == 0) ? exp_q0.size() : exp_q1.size();
  endfunction

  function automatic logic [9:0] q_head(input int k);
    return (k == 0) ? exp_q0[0] : exp_q1[0];
  endfunction

  task automatic q_push(input int k, input logic [9:0] v);
    if (k == 0) exp_q0.push_back(v);
    else        exp_q1.push_back(v);
  endtask

  task automatic q_pop(input int k);
    logic [9:0] d;
    if (k == 0) d = exp_q0.pop_front();
    else        d = exp_q1.pop_front();
  endtask

  task automatic model_clear();
    exp_q0.delete();
    exp_q1.delete();
    pfx.delete();
    pause_left = 0;
    m_perr = 1'b0;
    m_band = 1'b0;
    for (int k = 0; k < 2; k++) begin
      m_ovf[k]     = 1'b0;
      rep_valid[k] = 1'b0;
    end
  endtask

  // Reference decoder: what one byte means given the prefixes seen so far.
  task automatic ref_byte(input logic [7:0] b, output bit has, output logic [9:0] ev, output bit err);
    bit brk_seen;
    has = 1'b0;
    ev  = '0;
    err = 1'b0;
    if (pause_left > 0) begin
      pause_left--;
      if (pause_left == 0) begin
        has = 1'b1;
        ev  = {8'hE1, 2'b00};
      end
    end else if (pfx.size() == 0) begin
      if (b == 8'hE1)                     pause_left = PAUSE_LEN - 1;
      else if (b == 8'hE0 || b == 8'hF0)  pfx.push_back(b);
      else if (!is_ign(b)) begin
        has = 1'b1;
        ev  = {b, 2'b00};
      end
    end else begin
      brk_seen = 1'b0;
      foreach (pfx[i]) if (pfx[i] == 8'hF0) brk_seen = 1'b1;
      if (b == 8'hF0 && pfx.size() == 1 && pfx[0] == 8'hE0) begin
        pfx.push_back(b);
      end else if (b == 8'hE0 || b == 8'hE1 || b == 8'hF0) begin
        err = 1'b1;
        pfx.delete();
      end else begin
        has = 1'b1;
        ev  = {b, pfx[0] == 8'hE0, brk_seen};
        pfx.delete();
      end
    end
  endtask

  // Advances the model by the inputs applied on the coming falling edge.
  task automatic model_step();
    bit has, err, push, pop, drop;
    logic [9:0] ev;
    has = 1'b0;
    err = 1'b0;
    ev  = '0;
    if (din_valid) ref_byte(din, has, ev, err);
    m_perr = err;
    m_band = 1'b0;
    foreach (pfx[i]) if (pfx[i] == 8'hF0) m_band = 1'b1;
    for (int k = 0; k < 2; k++) begin
      push = has;
      if (k == 1 && has) begin
        if (!ev[0]) begin
          if (rep_valid[1] && rep_key[1] == ev[9:1]) push = 1'b0;
          else begin
            rep_valid[1] = 1'b1;
            rep_key[1]   = ev[9:1];
          end
        end else if (rep_valid[1] && rep_key[1] == ev[9:1]) begin
          rep_valid[1] = 1'b0;
        end
      end
      pop = (q_size(k) > 0) && ev_ready;
      if (pop) q_pop(k);
      drop = 1'b0;
      if (push) begin
        if (q_size(k) < DEPTH) q_push(k, ev);
        else                   drop = 1'b1;
      end
      if (drop)         m_ovf[k] = 1'b1;
      else if (ovf_clr) m_ovf[k] = 1'b0;
    end
  endtask

  task automatic check_inst(input int k);
    logic v, e, b, o;
    logic [7:0] c;
    logic [FW-1:0] f;
    logic [9:0] h;
    if (k == 0) begin v = ev_valid0; c = ev_code0; e = ev_ext0; b = ev_break0; o = overflow0; f = fill0; end
    else        begin v = ev_valid1; c = ev_code1; e = ev_ext1; b = ev_break1; o = overflow1; f = fill1; end
    chk($sformatf("ev_valid%0d", k), v, q_size(k) > 0);
    chk($sformatf("fill%0d", k), f, q_size(k));
    chk($sformatf("overflow%0d", k), o, m_ovf[k]);
    if (q_size(k) > 0) begin
      h = q_head(k);
      chk($sformatf("ev_code%0d", k), c, h[9:2]);
      chk($sformatf("ev_ext%0d", k), e, h[1]);
      chk($sformatf("ev_break%0d", k), b, h[0]);
    end
  endtask

  // Monitor: between edges, compare then advance the model.
  initial begin
    forever begin
      @(posedge clk_rx);
      #1;
      if (reset) begin
        chk("bandera0", bandera0, m_band);
        chk("bandera1", bandera1, m_band);
        chk("proto_err0", proto_err0, m_perr);
        chk("proto_err1", proto_err1, m_perr);
        check_inst(0);
        check_inst(1);
        model_step();
      end
    end
  end

  // Driver tasks
  task automatic cyc(input bit v, input logic [7:0] b);
    @(posedge clk_rx);
    din_valid = v;
    din       = b;
  endtask

  task automatic send(input logic [7:0] b);
    cyc(1'b1, b);
    cyc(1'b0, 8'h00);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 8'h00);
  endtask

  task automatic do_reset();
    @(posedge clk_rx);
    reset     = 1'b0;
    din_valid = 1'b0;
    ovf_clr   = 1'b0;
    #2;
    chk("rst_ev_valid0", ev_valid0, 0);
    chk("rst_ev_valid1", ev_valid1, 0);
    chk("rst_fill0", fill0, 0);
    chk("rst_fill1", fill1, 0);
    chk("rst_bandera0", bandera0, 0);
    chk("rst_bandera1", bandera1, 0);
    chk("rst_proto_err0", proto_err0, 0);
    chk("rst_overflow0", overflow0, 0);
    chk("rst_overflow1", overflow1, 0);
    chk("rst_ev_code0", ev_code0, 0);
    chk("rst_ev_ext0", ev_ext0, 0);
    chk("rst_ev_break0", ev_break0, 0);
    model_clear();
    repeat (2) @(posedge clk_rx);
    reset = 1'b1;
  endtask

  logic [7:0] ign_tab[6]  = '{8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF};
  logic [7:0] code_tab[8] = '{8'h1C, 8'h1D, 8'h75, 8'h15, 8'h6B, 8'h5A, 8'h1C, 8'h75};

  initial begin
    int pick;
    int n;
    do_reset();
    ev_ready = 1'b1;

    // Plain make, then break.
    send(8'h1C);
    send(8'hF0); send(8'h1C);
    idle(3);
    // Extended make and break.
    send(8'hE0); send(8'h75);
    send(8'hE0); send(8'hF0); send(8'h75);
    idle(3);
    // Pause: E1 plus seven arbitrary bytes, back to back.
    cyc(1'b1, 8'hE1);
    for (int i = 0; i < PAUSE_LEN - 1; i++) cyc(1'b1, 8'($urandom_range(0, 255)));
    idle(3);
    // Illegal prefix pair, recovery, ignored bytes.
    send(8'hF0); send(8'hE0);
    send(8'h1C);
    send(8'hAA); send(8'hFA);
    idle(3);

    // Overflow: five makes into a four-deep FIFO with no consumer.
    ev_ready = 1'b0;
    send(8'h15); send(8'h1D); send(8'h24); send(8'h2D); send(8'h2C);
    // Push and pop on the same edge while full.
    @(posedge clk_rx);
    ev_ready = 1'b1; din_valid = 1'b1; din = 8'h35;
    @(posedge clk_rx);
    ev_ready = 1'b0; din_valid = 1'b0;
    idle(1);
    @(posedge clk_rx); ovf_clr = 1'b1;
    @(posedge clk_rx); ovf_clr = 1'b0;
    ev_ready = 1'b1;
    idle(6);

    // Typematic repeat pattern.
    send(8'h1C); send(8'h1C); send(8'h1C);
    send(8'hF0); send(8'h1C);
    send(8'h1C); send(8'h1C);
    idle(4);

    // Reset mid-sequence with events queued.
    ev_ready = 1'b0;
    send(8'h15); send(8'h1D);
    send(8'hE0); send(8'hF0);
    do_reset();
    send(8'h75);
    idle(2);
    ev_ready = 1'b1;
    idle(4);

    // Randomized traffic.
    for (int i = 0; i < 1500; i++) begin
      @(posedge clk_rx);
      din_valid = 1'($urandom_range(0, 1));
      pick = $urandom_range(0, 99);
      if (pick < 6)       din = 8'hE0;
      else if (pick < 13) din = 8'hF0;
      else if (pick < 15) din = 8'hE1;
      else if (pick < 21) din = ign_tab[$urandom_range(0, 5)];
      else                din = code_tab[$urandom_range(0, 7)];
      ev_ready = ($urandom_range(0, 9) < 6);
      ovf_clr  = ($urandom_range(0, 19) == 0);
    end

    // Drain with a bounded wait.
    @(posedge clk_rx);
    din_valid = 1'b0;
    ovf_clr   = 1'b0;
    ev_ready  = 1'b1;
    n = 0;
    while ((exp_q0.size() > 0 || exp_q1.size() > 0) && n < 50) begin
      @(posedge clk_rx);
      n++;
    end
    if (n >= 50) begin
      total++;
      bad++;
      $display("FAIL drain_timeout: queues %0d/%0d still pending, expected 0", exp_q0.size(), exp_q1.size());
    end
    repeat (3) @(posedge clk_rx);
    #2;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
